// File: rtl/arp_mac_learner.sv
// arp_mac_learner
//
// Passive monitor on the host-side GMII receive stream. It parses each frame
// (preamble/SFD, destination, source, payload, FCS), checks CRC-32, length and
// receive-error flags, and learns the host's unicast source MAC once the same
// address has appeared in LEARN_COUNT consecutive good frames. The stream
// itself is never modified or delayed; this block only observes it.
//
// Ports:
//   clk          byte clock
//   rst          synchronous, active-high reset
//   up_data      GMII receive data byte
//   up_dv        data valid; a frame is one contiguous dv-high run
//   up_er        receive error
//   mac_address  learned MAC, first wire byte in [47:40]
//   mac_valid    sticky once an address has been locked
//   good_frames  count of frames passing every check (wraps)
//   bad_frames   count of frames failing any check (wraps)

module arp_mac_learner #(
  parameter int LEARN_COUNT = 4,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  up_data,
  input  logic        up_dv,
  input  logic        up_er,
  output logic [47:0] mac_address,
  output logic        mac_valid,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    BODY,
    DROP
  } state_t;

  localparam logic [3:0]  LC        = 4'(LEARN_COUNT);
  localparam logic [10:0] MIN_L     = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L     = 11'(MAX_LEN);
  localparam logic [31:0] CRC_RESID = 32'hDEBB20E3;

  state_t      state;
  state_t      state_nxt;
  logic        dv_d;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        err;
  logic [47:0] src_shift;
  logic [47:0] cand;
  logic [3:0]  match_cnt;

  logic        start;
  logic        sfd_hit;
  logic        drop_hit;
  logic        accept;
  logic        frame_end;
  logic        frame_good;
  logic        frame_bad;
  logic        src_ok;
  logic [3:0]  cnt_up;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // A frame may only start on a dv rising edge; dv_d resets high so a frame
  // already running when reset releases is ignored until dv drops.
  assign start = up_dv && !dv_d;

  // State register for the frame parser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: walk preamble, header and body, bailing out to DROP on
  // any malformed preamble and back to IDLE whenever dv falls.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (up_data == 8'h55)      state_nxt = PRE;
          else if (up_data == 8'hD5) state_nxt = HDR;
          else                       state_nxt = DROP;
        end
      end
      PRE: begin
        if (!up_dv)                  state_nxt = IDLE;
        else if (up_data == 8'hD5)   state_nxt = HDR;
        else if (up_data != 8'h55)   state_nxt = DROP;
      end
      HDR: begin
        if (!up_dv)                  state_nxt = IDLE;
        else if (byte_cnt == 11'd13) state_nxt = BODY;
      end
      BODY: begin
        if (!up_dv)                  state_nxt = IDLE;
      end
      DROP: begin
        if (!up_dv)                  state_nxt = IDLE;
      end
      default:                       state_nxt = IDLE;
    endcase
  end

  // Output decode: per-cycle strobes for the datapath, counters and learner.
  // A drop is counted when it is entered with dv high; a frame ending in HDR
  // is always too short, so only a BODY ending can be good.
  always_comb begin
    sfd_hit    = 1'b0;
    drop_hit   = 1'b0;
    accept     = 1'b0;
    frame_end  = 1'b0;
    frame_good = 1'b0;
    case (state)
      IDLE: begin
        sfd_hit  = start && (up_data == 8'hD5);
        drop_hit = start && (up_data != 8'hD5) && (up_data != 8'h55);
      end
      PRE: begin
        sfd_hit  = up_dv && (up_data == 8'hD5);
        drop_hit = up_dv && (up_data != 8'hD5) && (up_data != 8'h55);
      end
      HDR: begin
        accept    = up_dv;
        frame_end = !up_dv;
      end
      BODY: begin
        accept     = up_dv;
        frame_end  = !up_dv;
        frame_good = !up_dv && !err && (crc == CRC_RESID) &&
                     (byte_cnt >= MIN_L) && (byte_cnt <= MAX_L);
      end
      default: begin
      end
    endcase
    frame_bad = drop_hit || (frame_end && !frame_good);
  end

  // Frame datapath: byte counter, running CRC, error flag and source capture.
  // The SFD seeds the CRC; bytes 6..11 after it are the source address.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_d      <= 1'b1;
      byte_cnt  <= 11'd0;
      crc       <= 32'hFFFFFFFF;
      err       <= 1'b0;
      src_shift <= 48'd0;
    end else begin
      dv_d <= up_dv;
      if (sfd_hit) begin
        byte_cnt <= 11'd0;
        crc      <= 32'hFFFFFFFF;
        err      <= 1'b0;
      end else if (accept) begin
        crc <= crc_next(crc, up_data);
        if (byte_cnt != 11'h7FF) begin
          byte_cnt <= byte_cnt + 11'd1;
        end
        if (up_er) begin
          err <= 1'b1;
        end
        if ((byte_cnt >= 11'd6) && (byte_cnt <= 11'd11)) begin
          src_shift <= {src_shift[39:0], up_data};
        end
      end
    end
  end

  // Frame verdict counters; they keep running after the address is locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_frames <= 16'd0;
      bad_frames  <= 16'd0;
    end else begin
      if (frame_good) good_frames <= good_frames + 16'd1;
      if (frame_bad)  bad_frames  <= bad_frames + 16'd1;
    end
  end

  assign src_ok = !src_shift[40] && (src_shift != 48'd0);
  assign cnt_up = (match_cnt == LC) ? match_cnt : match_cnt + 4'd1;

  // Learner: track a candidate source and how many consecutive good frames
  // carried it. Any bad or ineligible frame breaks the run. Locking is final
  // until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= 48'd0;
      match_cnt   <= 4'd0;
      mac_address <= 48'd0;
      mac_valid   <= 1'b0;
    end else if (!mac_valid) begin
      if (frame_good) begin
        if (!src_ok) begin
          match_cnt <= 4'd0;
        end else if (src_shift == cand) begin
          match_cnt <= cnt_up;
          if (cnt_up == LC) begin
            mac_address <= cand;
            mac_valid   <= 1'b1;
          end
        end else begin
          cand      <= src_shift;
          match_cnt <= 4'd1;
          if (LC == 4'd1) begin
            mac_address <= src_shift;
            mac_valid   <= 1'b1;
          end
        end
      end else if (frame_bad) begin
        match_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_arp_mac_learner.sv
// tb_arp_mac_learner
//
// Directed bench for arp_mac_learner. A table of frame records drives most of
// the checks; mid-frame reset is a hand-written sequence. Frames are built
// with a correct FCS unless a record asks for a corrupted one.

module tb_arp_mac_learner;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  up_data;
  logic        up_dv;
  logic        up_er;
  logic [47:0] mac_address;
  logic        mac_valid;
  logic [15:0] good_frames;
  logic [15:0] bad_frames;

  localparam logic [47:0] S1 = 48'h021122334455;
  localparam logic [47:0] S2 = 48'h021122334466;
  localparam logic [47:0] S3 = 48'h031122334455;
  localparam logic [47:0] S4 = 48'h0A0B0C0D0E0F;

  typedef struct {
    bit          doReset;
    logic [47:0] src;
    int          len;
    bit          badFcs;
    bit          erPulse;
    bit          badPre;
    int          expGood;
    int          expBad;
    bit          expValid;
    logic [47:0] expMac;
  } vec_t;

  vec_t        vecs [0:38];
  logic [7:0]  wire_bytes [0:1599];
  int          wire_len;
  int          total = 0;
  int          bad = 0;
  int          prevGood = 0;
  bit          prevValid = 1'b0;

  arp_mac_learner dut (
    .clk         (clk),
    .rst         (rst),
    .up_data     (up_data),
    .up_dv       (up_dv),
    .up_er       (up_er),
    .mac_address (mac_address),
    .mac_valid   (mac_valid),
    .good_frames (good_frames),
    .bad_frames  (bad_frames)
  );

  // Free-running byte clock.
  always #5 clk = ~clk;

  // Standard Ethernet CRC-32 step used to generate frame FCS fields.
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Preamble (7 bytes, optionally with a 0x5D), SFD, then len bytes counted
  // from the SFD: dst, src, ethertype 0x0806, counting payload, FCS.
  task automatic buildFrame(input logic [47:0] src, input int len, input bit badFcs, input bit badPre);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      wire_bytes[n] = (badPre && i == 2) ? 8'h5D : 8'h55;
      n++;
    end
    wire_bytes[n] = 8'hD5;
    n++;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < len - 4; k++) begin
      if (k < 6)       b = 8'hA0 + 8'(k);
      else if (k < 12) b = src[47 - 8 * (k - 6) -: 8];
      else if (k == 12) b = 8'h08;
      else if (k == 13) b = 8'h06;
      else             b = 8'(k);
      wire_bytes[n] = b;
      n++;
      c = crcByte(c, b);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) begin
      wire_bytes[n] = c[8 * j +: 8];
      n++;
    end
    if (badFcs) wire_bytes[n - 1] = wire_bytes[n - 1] ^ 8'hFF;
    wire_len = n;
  endtask

  // Drive the built frame one byte per clock; returns just after the last
  // byte's edge with dv already low, so the verdict edge is still ahead.
  task automatic applyStimulus(input int erAt, input int resetAt);
    for (int i = 0; i < wire_len; i++) begin
      up_data = wire_bytes[i];
      up_dv   = 1'b1;
      up_er   = (i == erAt);
      if (i == resetAt)     rst = 1'b1;
      if (i == resetAt + 2) rst = 1'b0;
      @(posedge clk);
      #1;
    end
    up_dv   = 1'b0;
    up_er   = 1'b0;
    up_data = 8'h00;
  endtask

  task automatic endFrame();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    up_dv   = 1'b0;
    up_er   = 1'b0;
    up_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_good", 48'(good_frames), 48'd0);
    checkOutput("reset_bad", 48'(bad_frames), 48'd0);
    checkOutput("reset_valid", 48'(mac_valid), 48'd0);
    checkOutput("reset_mac", mac_address, 48'd0);
    prevGood  = 0;
    prevValid = 1'b0;
  endtask

  task automatic runRange(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i <= hi; i++) begin
      v = vecs[i];
      if (v.doReset) resetDut();
      buildFrame(v.src, v.len, v.badFcs, v.badPre);
      applyStimulus(v.erPulse ? 30 : -1, -1);
      checkOutput($sformatf("v%0d_pre_good", i), 48'(good_frames), 48'(prevGood));
      checkOutput($sformatf("v%0d_pre_valid", i), 48'(mac_valid), 48'(prevValid));
      endFrame();
      checkOutput($sformatf("v%0d_good", i), 48'(good_frames), 48'(v.expGood));
      checkOutput($sformatf("v%0d_bad", i), 48'(bad_frames), 48'(v.expBad));
      checkOutput($sformatf("v%0d_valid", i), 48'(mac_valid), 48'(v.expValid));
      checkOutput($sformatf("v%0d_mac", i), mac_address, v.expMac);
      prevGood  = v.expGood;
      prevValid = v.expValid;
    end
  endtask

  initial begin
    // Lock on four good frames.
    for (int k = 0; k < 4; k++) begin
      vecs[k] = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, k + 1, 0, (k == 3), (k == 3) ? S1 : 48'd0};
    end
    // Corrupted FCS on frame 3 restarts the run; lock after frame 7.
    vecs[4]  = '{1'b1, S1, 64, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 48'd0};
    vecs[5]  = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 48'd0};
    vecs[6]  = '{1'b0, S1, 64, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0, 48'd0};
    vecs[7]  = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 48'd0};
    vecs[8]  = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 4, 1, 1'b0, 48'd0};
    vecs[9]  = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 5, 1, 1'b0, 48'd0};
    vecs[10] = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 6, 1, 1'b1, S1};
    // Alternating sources then multicast: never locks.
    for (int k = 0; k < 10; k++) begin
      vecs[11 + k] = '{(k == 0), (k % 2 == 0) ? S1 : S2, 64, 1'b0, 1'b0, 1'b0, k + 1, 0, 1'b0, 48'd0};
    end
    for (int k = 0; k < 5; k++) begin
      vecs[21 + k] = '{1'b0, S3, 64, 1'b0, 1'b0, 1'b0, 11 + k, 0, 1'b0, 48'd0};
    end
    // Error pulse, 63 bytes, 1523 bytes, bad preamble, HDR-short, 1522 good.
    vecs[26] = '{1'b0, S1, 64,   1'b0, 1'b1, 1'b0, 15, 1, 1'b0, 48'd0};
    vecs[27] = '{1'b0, S1, 63,   1'b0, 1'b0, 1'b0, 15, 2, 1'b0, 48'd0};
    vecs[28] = '{1'b0, S1, 1523, 1'b0, 1'b0, 1'b0, 15, 3, 1'b0, 48'd0};
    vecs[29] = '{1'b0, S1, 64,   1'b0, 1'b0, 1'b1, 15, 4, 1'b0, 48'd0};
    vecs[30] = '{1'b0, S1, 10,   1'b0, 1'b0, 1'b0, 15, 5, 1'b0, 48'd0};
    vecs[31] = '{1'b0, S2, 1522, 1'b0, 1'b0, 1'b0, 16, 5, 1'b0, 48'd0};
    // Continue after the mid-frame reset sequence: lock, then ignore S4.
    vecs[32] = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 48'd0};
    vecs[33] = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 48'd0};
    vecs[34] = '{1'b0, S1, 64, 1'b0, 1'b0, 1'b0, 4, 0, 1'b1, S1};
    for (int k = 0; k < 4; k++) begin
      vecs[35 + k] = '{1'b0, S4, 64, 1'b0, 1'b0, 1'b0, 5 + k, 0, 1'b1, S1};
    end

    resetDut();
    runRange(0, 31);

    // Reset asserted mid-frame with dv held high: the remainder is ignored.
    resetDut();
    buildFrame(S1, 64, 1'b0, 1'b0);
    applyStimulus(-1, 20);
    endFrame();
    checkOutput("cut_good", 48'(good_frames), 48'd0);
    checkOutput("cut_bad", 48'(bad_frames), 48'd0);
    buildFrame(S1, 64, 1'b0, 1'b0);
    applyStimulus(-1, -1);
    endFrame();
    checkOutput("after_cut_good", 48'(good_frames), 48'd1);
    checkOutput("after_cut_bad", 48'(bad_frames), 48'd0);
    checkOutput("after_cut_valid", 48'(mac_valid), 48'd0);
    prevGood  = 1;
    prevValid = 1'b0;

    runRange(32, 38);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
